// File: rtl/pipe_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_if
// Purpose : groups the handshake between the pipeRV32N sequencer and the five
//           pipeline stages into one bundle.
// Signals :
//   if_done..wb_done  stage finished its work this cycle
//   id_req_nop        ID load-use hazard request
//   id_req_jal        ID decoded a valid jal
//   ex_req_redirect   EX resolved a taken branch / jalr
//   wb_error_code     error code of the instruction leaving WB (0 = no error)
//   if_en..wb_en      stage register load enables
//   if_nop, id_nop    force a bubble into the IF / ID output registers
//   pc_sel            00 pc+4, 01 jal target, 10 EX redirect target
//   halted            core stopped on a retired error
//   halt_error        error code that caused the halt
// Modports: master = sequencer (pipe_ctrl), slave = pipeline stages.
// -----------------------------------------------------------------------------
interface pipe_ctrl_if #(
  parameter int ERROR_WIDTH = 2
) ();
  logic                   if_done;
  logic                   id_done;
  logic                   ex_done;
  logic                   mem_done;
  logic                   wb_done;
  logic                   id_req_nop;
  logic                   id_req_jal;
  logic                   ex_req_redirect;
  logic [ERROR_WIDTH-1:0] wb_error_code;
  logic                   if_en;
  logic                   id_en;
  logic                   ex_en;
  logic                   mem_en;
  logic                   wb_en;
  logic                   if_nop;
  logic                   id_nop;
  logic [1:0]             pc_sel;
  logic                   halted;
  logic [ERROR_WIDTH-1:0] halt_error;

  modport master (
    input  if_done, id_done, ex_done, mem_done, wb_done,
    input  id_req_nop, id_req_jal, ex_req_redirect, wb_error_code,
    output if_en, id_en, ex_en, mem_en, wb_en,
    output if_nop, id_nop, pc_sel, halted, halt_error
  );

  modport slave (
    output if_done, id_done, ex_done, mem_done, wb_done,
    output id_req_nop, id_req_jal, ex_req_redirect, wb_error_code,
    input  if_en, id_en, ex_en, mem_en, wb_en,
    input  if_nop, id_nop, pc_sel, halted, halt_error
  );
endinterface

// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl
// Purpose : central sequencer for the 5-stage pipeRV32N pipeline. Generates the
//           per-stage load enables and bubble controls, selects the next fetch
//           PC source and halts the core when an erroneous instruction retires.
// Ports   :
//   clk    in   clock, rising edge
//   reset  in   synchronous, active-high
//   bus    pipe_ctrl_if.master (stage done flags, requests, enables, nops,
//          pc_sel, halted, halt_error)
//   perf_cycles/perf_stalls/perf_flushes (32 bit, only with PIPE_CTRL_PERF_EN)
// Parameters:
//   ERROR_WIDTH   width of the core error code (0 = no error)
//   FLUSH_CYCLES  IF bubble cycles after an EX redirect (1..3)
// Configuration macro: PIPE_CTRL_PERF_EN adds the performance counters.
// State, flush counter and halt_error are registered; the stage controls are
// decoded combinationally from the state and this cycle's requests so a stall
// or redirect takes effect in the same cycle it is raised.
// -----------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int ERROR_WIDTH  = 2,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  pipe_ctrl_if.master bus
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_stalls,
  output logic [31:0] perf_flushes
`endif
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_t;

  // Counter reload after a redirect: the redirect cycle itself is the first
  // bubble, so FLUSH covers the remaining FLUSH_CYCLES-1.
  localparam logic [1:0] CNT_LOAD = 2'(FLUSH_CYCLES - 1);

  state_t                 state_r;
  logic [1:0]             cnt_r;
  logic [ERROR_WIDTH-1:0] halt_error_r;

  logic                   all_done_s;
  logic                   error_s;
  logic [4:0]             en_s;       // {if, id, ex, mem, wb}
  logic                   if_nop_s;
  logic                   id_nop_s;
  logic [1:0]             pc_sel_s;
  logic                   halted_s;
  logic                   stall_s;    // priority 3 or 5 cycle
  logic                   flush_s;    // priority 4 or 6 cycle

  assign all_done_s = bus.if_done & bus.id_done & bus.ex_done & bus.mem_done & bus.wb_done;

  // An error only retires when WB would actually advance, i.e. the whole
  // pipe is done and the core is not already halted.
  assign error_s = (state_r != HALT) && all_done_s &&
                   (bus.wb_error_code != {ERROR_WIDTH{1'b0}});

  // Priority decode of the stage controls.
  always_comb begin
    en_s     = 5'b00000;
    if_nop_s = 1'b1;
    id_nop_s = 1'b1;
    pc_sel_s = 2'b00;
    halted_s = 1'b0;
    stall_s  = 1'b0;
    flush_s  = 1'b0;
    if (reset) begin
      en_s = 5'b00000;
    end else if (state_r == HALT) begin
      halted_s = 1'b1;
    end else if (error_s) begin
      en_s     = 5'b00001;
      if_nop_s = 1'b0;
      id_nop_s = 1'b0;
    end else if (!all_done_s) begin
      if_nop_s = 1'b0;
      id_nop_s = 1'b0;
      stall_s  = 1'b1;
    end else if (bus.ex_req_redirect) begin
      en_s     = 5'b11111;
      pc_sel_s = 2'b10;
      flush_s  = 1'b1;
    end else if (bus.id_req_nop) begin
      en_s     = 5'b01111;
      if_nop_s = (state_r == FLUSH);
      id_nop_s = 1'b1;
      stall_s  = 1'b1;
    end else if (bus.id_req_jal) begin
      en_s     = 5'b11111;
      pc_sel_s = 2'b01;
      id_nop_s = 1'b0;
      flush_s  = 1'b1;
    end else begin
      en_s     = 5'b11111;
      if_nop_s = (state_r == FLUSH);
      id_nop_s = 1'b0;
    end
  end

  // FSM: state, flush counter and latched halt error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= RUN;
      cnt_r        <= 2'd0;
      halt_error_r <= {ERROR_WIDTH{1'b0}};
    end else begin
      case (state_r)
        RUN, FLUSH: begin
          if (error_s) begin
            state_r      <= HALT;
            cnt_r        <= 2'd0;
            halt_error_r <= bus.wb_error_code;
          end else if (!all_done_s) begin
            // Frozen: requests are re-presented next cycle.
            state_r <= state_r;
            cnt_r   <= cnt_r;
          end else if (bus.ex_req_redirect) begin
            if (FLUSH_CYCLES > 1) begin
              state_r <= FLUSH;
              cnt_r   <= CNT_LOAD;
            end else begin
              state_r <= RUN;
              cnt_r   <= 2'd0;
            end
          end else if (state_r == FLUSH) begin
            if (cnt_r == 2'd1) begin
              state_r <= RUN;
              cnt_r   <= 2'd0;
            end else begin
              cnt_r <= cnt_r - 2'd1;
            end
          end else begin
            state_r <= state_r;
            cnt_r   <= cnt_r;
          end
        end
        HALT: begin
          state_r <= HALT;
        end
        default: begin
          state_r <= RUN;
          cnt_r   <= 2'd0;
        end
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  // Wrap-around performance counters, frozen once halted.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cycles  <= 32'd0;
      perf_stalls  <= 32'd0;
      perf_flushes <= 32'd0;
    end else if (state_r != HALT) begin
      perf_cycles  <= perf_cycles + 32'd1;
      perf_stalls  <= perf_stalls + {31'd0, stall_s};
      perf_flushes <= perf_flushes + {31'd0, flush_s};
    end else begin
      perf_cycles  <= perf_cycles;
      perf_stalls  <= perf_stalls;
      perf_flushes <= perf_flushes;
    end
  end
`endif

  assign bus.if_en      = en_s[4];
  assign bus.id_en      = en_s[3];
  assign bus.ex_en      = en_s[2];
  assign bus.mem_en     = en_s[1];
  assign bus.wb_en      = en_s[0];
  assign bus.if_nop     = if_nop_s;
  assign bus.id_nop     = id_nop_s;
  assign bus.pc_sel     = pc_sel_s;
  assign bus.halted     = halted_s;
  // The latch clears on the reset edge; mask it so it already reads 0 while
  // reset is held.
  assign bus.halt_error = reset ? {ERROR_WIDTH{1'b0}} : halt_error_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl
// Directed testbench for pipe_ctrl (FLUSH_CYCLES=2). Inputs change 1 time unit
// after the rising edge, outputs are compared 2 units later, well before the
// next edge. Expected values are hand-derived constants.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

  logic clk;
  logic reset;
  int   assert_cnt;
  int   fail_cnt;

  pipe_ctrl_if #(.ERROR_WIDTH(2)) bus ();

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_cycles;
  logic [31:0] perf_stalls;
  logic [31:0] perf_flushes;
`endif

  pipe_ctrl #(
    .ERROR_WIDTH (2),
    .FLUSH_CYCLES(2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_cycles (perf_cycles),
    .perf_stalls (perf_stalls),
    .perf_flushes(perf_flushes)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // en = {if, id, ex, mem, wb}, nops = {if_nop, id_nop}
  task automatic expect_out(input string tag, input logic [4:0] en, input logic [1:0] nops,
                            input logic [1:0] pc, input logic hlt, input logic [1:0] herr);
    #2;
    check_val({tag, "/en"}, {27'd0, bus.if_en, bus.id_en, bus.ex_en, bus.mem_en, bus.wb_en},
              {27'd0, en});
    check_val({tag, "/nop"}, {30'd0, bus.if_nop, bus.id_nop}, {30'd0, nops});
    check_val({tag, "/pc_sel"}, {30'd0, bus.pc_sel}, {30'd0, pc});
    check_val({tag, "/halted"}, {31'd0, bus.halted}, {31'd0, hlt});
    check_val({tag, "/halt_error"}, {30'd0, bus.halt_error}, {30'd0, herr});
  endtask

  task automatic set_req(input logic nop, input logic jal, input logic redir, input logic [1:0] err);
    bus.id_req_nop      = nop;
    bus.id_req_jal      = jal;
    bus.ex_req_redirect = redir;
    bus.wb_error_code   = err;
  endtask

  initial begin
    assert_cnt   = 0;
    fail_cnt     = 0;
    reset        = 1'b1;
    bus.if_done  = 1'b1;
    bus.id_done  = 1'b1;
    bus.ex_done  = 1'b1;
    bus.mem_done = 1'b1;
    bus.wb_done  = 1'b1;
    set_req(1'b0, 1'b0, 1'b0, 2'b00);

    // T1: reset held for 3 cycles, then free run
    expect_out("t1_rst", 5'b00000, 2'b11, 2'b00, 1'b0, 2'b00);
    tick(); tick(); tick();
    reset = 1'b0;
    expect_out("t1_run", 5'b11111, 2'b00, 2'b00, 1'b0, 2'b00);
    tick();

    // T2: one-cycle load-use stall
    set_req(1'b1, 1'b0, 1'b0, 2'b00);
    expect_out("t2_stall", 5'b01111, 2'b01, 2'b00, 1'b0, 2'b00);
    tick();
    set_req(1'b0, 1'b0, 1'b0, 2'b00);
    expect_out("t2_after", 5'b11111, 2'b00, 2'b00, 1'b0, 2'b00);
    tick();

    // T3: redirect beats jal, then one FLUSH cycle, then RUN
    set_req(1'b0, 1'b1, 1'b1, 2'b00);
    expect_out("t3_redir", 5'b11111, 2'b11, 2'b10, 1'b0, 2'b00);
    tick();
    set_req(1'b0, 1'b0, 1'b0, 2'b00);
    expect_out("t3_flush", 5'b11111, 2'b10, 2'b00, 1'b0, 2'b00);
    tick();
    expect_out("t3_run", 5'b11111, 2'b00, 2'b00, 1'b0, 2'b00);
    tick();

    // FLUSH counter frozen while the pipe is not done
    set_req(1'b0, 1'b0, 1'b1, 2'b00);
    tick();
    set_req(1'b0, 1'b0, 1'b0, 2'b00);
    bus.mem_done = 1'b0;
    expect_out("fz_wait", 5'b00000, 2'b00, 2'b00, 1'b0, 2'b00);
    tick();
    bus.mem_done = 1'b1;
    expect_out("fz_flush", 5'b11111, 2'b10, 2'b00, 1'b0, 2'b00);
    tick();
    expect_out("fz_run", 5'b11111, 2'b00, 2'b00, 1'b0, 2'b00);
    tick();

    // New redirect while in FLUSH reloads the counter
    set_req(1'b0, 1'b0, 1'b1, 2'b00);
    tick();
    expect_out("rl_redir", 5'b11111, 2'b11, 2'b10, 1'b0, 2'b00);
    tick();
    set_req(1'b0, 1'b0, 1'b0, 2'b00);
    expect_out("rl_flush", 5'b11111, 2'b10, 2'b00, 1'b0, 2'b00);
    tick();
    expect_out("rl_run", 5'b11111, 2'b00, 2'b00, 1'b0, 2'b00);
    tick();

    // T4: jal held while mem_done=0 for 2 cycles
    set_req(1'b0, 1'b1, 1'b0, 2'b00);
    bus.mem_done = 1'b0;
    expect_out("t4_wait0", 5'b00000, 2'b00, 2'b00, 1'b0, 2'b00);
    tick();
    expect_out("t4_wait1", 5'b00000, 2'b00, 2'b00, 1'b0, 2'b00);
    tick();
    bus.mem_done = 1'b1;
    expect_out("t4_jal", 5'b11111, 2'b10, 2'b01, 1'b0, 2'b00);
    tick();
    set_req(1'b0, 1'b0, 1'b0, 2'b00);
    expect_out("t4_run", 5'b11111, 2'b00, 2'b00, 1'b0, 2'b00);
    tick();

    // T5: error retires (beats a same-cycle redirect), then HALT until reset
    set_req(1'b0, 1'b0, 1'b1, 2'b01);
    expect_out("t5_err", 5'b00001, 2'b00, 2'b00, 1'b0, 2'b00);
    tick();
    set_req(1'b0, 1'b0, 1'b0, 2'b00);
    expect_out("t5_halt", 5'b00000, 2'b11, 2'b00, 1'b1, 2'b01);
    tick();
    set_req(1'b0, 1'b1, 1'b1, 2'b10);
    expect_out("t5_hold", 5'b00000, 2'b11, 2'b00, 1'b1, 2'b01);
    tick();
    set_req(1'b0, 1'b0, 1'b0, 2'b00);
    reset = 1'b1;
    expect_out("t5_rst", 5'b00000, 2'b11, 2'b00, 1'b0, 2'b00);
    tick();
    reset = 1'b0;
    expect_out("t5_run", 5'b11111, 2'b00, 2'b00, 1'b0, 2'b00);

`ifdef PIPE_CTRL_PERF_EN
    // T6: 10 cycles after reset with 2 stalls and 1 jal
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_req((i == 2) || (i == 5), (i == 7), 1'b0, 2'b00);
      tick();
    end
    set_req(1'b0, 1'b0, 1'b0, 2'b00);
    check_val("t6_cycles", perf_cycles, 32'd10);
    check_val("t6_stalls", perf_stalls, 32'd2);
    check_val("t6_flushes", perf_flushes, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
